btn_updown_counter: RTL and testbench

Parametrised successor to the single-button debounce/synchroniser/counter chain. Three push-buttons (up, down, clear) each pass through their own synchroniser, debouncer and auto-repeat logic, and drive one WIDTH-bit up/down counter. The counter has a selectable wrap or saturate mode. The block sits between the board buttons and the LED/display logic in the 10 MHz clock domain.

---
 rtl/btn_pkg.sv | 36 +++
 rtl/btn_conditioner.sv | 132 +++++++++++++
 rtl/btn_updown_counter.sv | 78 +++++++
 tb/tb_btn_updown_counter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Purpose: shared types and constants for the three-button up/down counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_pkg;

  // Per-button conditioner state.
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2
  } btn_state_t;

  // Default timing for a 10 MHz clock.
  localparam int DEF_WIDTH         = 8;
  localparam int DEF_DB_CYCLES     = 100000;   // 10 ms
  localparam int DEF_REPEAT_DELAY  = 5000000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD = 1000000;  // 100 ms
  localparam int DEF_WRAP          = 1;

  // Channel indices into the {clr, dn, up} vectors.
  localparam int UP      = 0;
  localparam int DN      = 1;
  localparam int CLR     = 2;
  localparam int NUM_BTN = 3;

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Purpose: one push-button: 2-flop synchroniser, debouncer, press/repeat FSM, event strobe.
// Latency: level_o rises DB_CYCLES+1 edges after the raw input is first sampled; evt_o one edge later.
// Backpressure: none; the event is a single-cycle strobe that the consumer must take.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic level_o,
  output logic evt_o
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DBW     = cnt_width(DB_CYCLES);
  localparam int RW      = cnt_width(REP_MAX);

  // Terminal counts; the delay value is unused when auto-repeat is disabled.
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]  DLY_LAST = (REPEAT_DELAY > 0) ? RW'(REPEAT_DELAY - 1) : '0;
  localparam logic [RW-1:0]  PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic           sync1_q, sync2_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  btn_state_t     state_q, state_d;
  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
  logic           evt_q, evt_d;

  // Two-flop synchroniser for the raw asynchronous button.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: the level flips only after DB_CYCLES consecutive differing samples.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DBW'(1);
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  // Press/repeat FSM. RELEASED only ever sees level_q high right after a
  // rising edge, so level_q there stands for the stable rising edge.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    evt_d     = 1'b0;
    case (state_q)
      RELEASED: begin
        rep_cnt_d = '0;
        if (level_q) begin
          state_d = HELD;
          evt_d   = 1'b1;
        end
      end
      HELD: begin
        if (!level_q) begin
          state_d   = RELEASED;
          rep_cnt_d = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (rep_cnt_q == DLY_LAST) begin
            state_d   = REPEAT;
            rep_cnt_d = '0;
            evt_d     = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
          end
        end
      end
      REPEAT: begin
        if (!level_q) begin
          state_d   = RELEASED;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == PER_LAST) begin
          rep_cnt_d = '0;
          evt_d     = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
      default: begin
        state_d   = RELEASED;
        rep_cnt_d = '0;
      end
    endcase
  end

  // FSM state, repeat counter and registered event strobe.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RELEASED;
      rep_cnt_q <= '0;
      evt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      evt_q     <= evt_d;
    end
  end

  assign level_o = level_q;
  assign evt_o   = evt_q;

endmodule

// File: rtl/btn_updown_counter.sv
// Purpose: three conditioned buttons (up, down, clear) driving one WIDTH-bit wrap/saturate counter.
// Latency: count_o changes one edge after the event strobe (DB_CYCLES+3 edges after a press is sampled).
// Backpressure: none; at most one count change per cycle, clear beats up/down.
module btn_updown_counter
  import btn_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int WRAP          = DEF_WRAP
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             btn_up_i,
  input  logic             btn_dn_i,
  input  logic             btn_clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic [2:0]       btn_level_o,
  output logic [2:0]       evt_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_evt;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               do_up, do_dn;

  assign btn_raw = {btn_clr_i, btn_dn_i, btn_up_i};

  // One conditioner per button; clear never auto-repeats.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_conditioner #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY ((i == CLR) ? 0 : REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_cond (
      .clk    (clk),
      .rst_n_i(rst_n_i),
      .btn_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .evt_o  (btn_evt[i])
    );
  end

  // Simultaneous up and down cancel each other.
  assign do_up = btn_evt[UP] & ~btn_evt[DN];
  assign do_dn = btn_evt[DN] & ~btn_evt[UP];

  // Next count: clear first, then a single step with wrap or saturate at the bounds.
  always_comb begin
    count_d = count_q;
    if (btn_evt[CLR]) begin
      count_d = '0;
    end else if (do_up) begin
      if ((WRAP != 0) || (count_q != CNT_MAX)) count_d = count_q + WIDTH'(1);
    end else if (do_dn) begin
      if ((WRAP != 0) || (count_q != '0)) count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Levels and strobes come straight from the conditioners' own registers.
  assign count_o     = count_q;
  assign btn_level_o = btn_level;
  assign evt_o       = btn_evt;

endmodule

// File: tb/tb_btn_updown_counter.sv
// Purpose: directed self-checking bench for btn_updown_counter (wrap, saturate and repeat builds).
// Latency: checks press latency k+5 level, k+6 strobe, k+7 count with DB_CYCLES=4.
// Backpressure: n/a.
module tb_btn_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up, dn, clr;
  logic [7:0] cnt_a, cnt_s, cnt_r;
  logic [2:0] lvl_a, lvl_s, lvl_r;
  logic [2:0] evt_a, evt_s, evt_r;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Wrapping counter, no auto-repeat.
  btn_updown_counter #(.WIDTH(8), .DB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(1), .WRAP(1)) dut_a (
    .clk(clk), .rst_n_i(rst_n), .btn_up_i(up), .btn_dn_i(dn), .btn_clr_i(clr),
    .count_o(cnt_a), .btn_level_o(lvl_a), .evt_o(evt_a));

  // Saturating counter, no auto-repeat.
  btn_updown_counter #(.WIDTH(8), .DB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(1), .WRAP(0)) dut_s (
    .clk(clk), .rst_n_i(rst_n), .btn_up_i(up), .btn_dn_i(dn), .btn_clr_i(clr),
    .count_o(cnt_s), .btn_level_o(lvl_s), .evt_o(evt_s));

  // Wrapping counter with auto-repeat.
  btn_updown_counter #(.WIDTH(8), .DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .WRAP(1)) dut_r (
    .clk(clk), .rst_n_i(rst_n), .btn_up_i(up), .btn_dn_i(dn), .btn_clr_i(clr),
    .count_o(cnt_r), .btn_level_o(lvl_r), .evt_o(evt_r));

  task automatic do_reset();
    rst_n = 1'b0;
    {clr, dn, up} = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full press and release of the buttons in m ({clr, dn, up}); long enough to settle.
  task automatic press(input logic [2:0] m);
    {clr, dn, up} = m;
    repeat (8) @(negedge clk);
    {clr, dn, up} = 3'b000;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {clr, dn, up} = 3'b000;
    repeat (2) @(negedge clk);
    checks++;
    if (cnt_a !== 8'd0 || cnt_s !== 8'd0 || cnt_r !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got a=%0d s=%0d r=%0d want 0", cnt_a, cnt_s, cnt_r);
    end
    checks++;
    if (lvl_a !== 3'b0 || lvl_s !== 3'b0 || lvl_r !== 3'b0) begin
      errors++;
      $display("FAIL reset_level got a=%b s=%b r=%b want 000", lvl_a, lvl_s, lvl_r);
    end
    checks++;
    if (evt_a !== 3'b0 || evt_s !== 3'b0 || evt_r !== 3'b0) begin
      errors++;
      $display("FAIL reset_evt got a=%b s=%b r=%b want 000", evt_a, evt_s, evt_r);
    end
  endtask

  // Hold up for 20 sampled cycles: level k+5..k+24, strobe at k+6, count 1 from k+7.
  task automatic test_press_latency();
    logic       exp_l, exp_e;
    logic [7:0] exp_c;
    do_reset();
    up = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_l = (c >= 5) && (c < 25);
      exp_e = (c == 6);
      exp_c = (c >= 7) ? 8'd1 : 8'd0;
      checks++;
      if (lvl_a[0] !== exp_l) begin
        errors++;
        $display("FAIL press_level cycle %0d got %b want %b", c, lvl_a[0], exp_l);
      end
      checks++;
      if (evt_a !== {2'b00, exp_e}) begin
        errors++;
        $display("FAIL press_evt cycle %0d got %b want %b", c, evt_a, {2'b00, exp_e});
      end
      checks++;
      if (cnt_a !== exp_c) begin
        errors++;
        $display("FAIL press_count cycle %0d got %0d want %0d", c, cnt_a, exp_c);
      end
      if (c == 19) up = 1'b0;
    end
    checks++;
    if (cnt_s !== 8'd1) begin
      errors++;
      $display("FAIL press_count_sat got %0d want 1", cnt_s);
    end
  endtask

  // 3 high / 2 low bursts never survive a 4-sample debounce.
  task automatic test_glitch();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        up = (c < 3);
        @(negedge clk);
        checks++;
        if (lvl_a !== 3'b0 || evt_a !== 3'b0) begin
          errors++;
          $display("FAIL glitch_quiet burst %0d got lvl=%b evt=%b want 000", r, lvl_a, evt_a);
        end
      end
    end
    up = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (cnt_a !== 8'd0 || lvl_a !== 3'b0) begin
      errors++;
      $display("FAIL glitch_count got cnt=%0d lvl=%b want 0/000", cnt_a, lvl_a);
    end
  endtask

  task automatic test_wrap_sat();
    // Down from 0: wraps to 255, saturates at 0.
    do_reset();
    press(3'b010);
    checks++;
    if (cnt_a !== 8'd255) begin
      errors++;
      $display("FAIL wrap_down got %0d want 255", cnt_a);
    end
    checks++;
    if (cnt_s !== 8'd0) begin
      errors++;
      $display("FAIL sat_down got %0d want 0", cnt_s);
    end
    // Count up to the top, then one more up.
    do_reset();
    repeat (255) press(3'b001);
    checks++;
    if (cnt_a !== 8'd255 || cnt_s !== 8'd255) begin
      errors++;
      $display("FAIL count_to_max got a=%0d s=%0d want 255", cnt_a, cnt_s);
    end
    press(3'b001);
    checks++;
    if (cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL wrap_up got %0d want 0", cnt_a);
    end
    checks++;
    if (cnt_s !== 8'd255) begin
      errors++;
      $display("FAIL sat_up got %0d want 255", cnt_s);
    end
  endtask

  // Press strobe at k+6, repeats at +10 then every 3; level drops at press+30.
  task automatic test_repeat();
    logic exp_e;
    int   n;
    n = 0;
    do_reset();
    up = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_e = (c == 6) || (c == 16) || (c == 19) || (c == 22) ||
              (c == 25) || (c == 28) || (c == 31) || (c == 34);
      checks++;
      if (evt_r[0] !== exp_e) begin
        errors++;
        $display("FAIL repeat_evt cycle %0d got %b want %b", c, evt_r[0], exp_e);
      end
      if (evt_r[0] === 1'b1) n++;
      if (c == 30) up = 1'b0;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL repeat_total got %0d want 8", n);
    end
    checks++;
    if (cnt_r !== 8'd8) begin
      errors++;
      $display("FAIL repeat_count got %0d want 8", cnt_r);
    end
    checks++;
    if (cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL norepeat_count got %0d want 1", cnt_a);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(3'b001);
    checks++;
    if (cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL simul_setup got %0d want 1", cnt_a);
    end
    // All three together: clear wins.
    {clr, dn, up} = 3'b111;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 6) begin
        checks++;
        if (evt_a !== 3'b111) begin
          errors++;
          $display("FAIL simul_all_evt got %b want 111", evt_a);
        end
      end
    end
    {clr, dn, up} = 3'b000;
    repeat (8) @(negedge clk);
    checks++;
    if (cnt_a !== 8'd0 || cnt_s !== 8'd0) begin
      errors++;
      $display("FAIL simul_all_count got a=%0d s=%0d want 0", cnt_a, cnt_s);
    end
    // Up and down together at 5: no change.
    repeat (5) press(3'b001);
    checks++;
    if (cnt_a !== 8'd5) begin
      errors++;
      $display("FAIL simul_setup5 got %0d want 5", cnt_a);
    end
    {clr, dn, up} = 3'b011;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 6) begin
        checks++;
        if (evt_a !== 3'b011) begin
          errors++;
          $display("FAIL simul_updn_evt got %b want 011", evt_a);
        end
      end
    end
    {clr, dn, up} = 3'b000;
    repeat (8) @(negedge clk);
    checks++;
    if (cnt_a !== 8'd5 || cnt_s !== 8'd5) begin
      errors++;
      $display("FAIL simul_updn_count got a=%0d s=%0d want 5", cnt_a, cnt_s);
    end
  endtask

  // Reset while up is mid-debounce; still held afterwards it counts as a fresh press.
  task automatic test_reset_mid();
    logic       exp_e, exp_l;
    logic [7:0] exp_c;
    int         n;
    n = 0;
    do_reset();
    press(3'b001);
    up = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (cnt_a !== 8'd0 || lvl_a !== 3'b0 || evt_a !== 3'b0) begin
        errors++;
        $display("FAIL midrst_hold got cnt=%0d lvl=%b evt=%b want 0/000/000", cnt_a, lvl_a, evt_a);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_e = (c == 6);
      exp_l = (c >= 5);
      exp_c = (c >= 7) ? 8'd1 : 8'd0;
      if (evt_a[0] === 1'b1) n++;
      checks++;
      if (evt_a[0] !== exp_e || lvl_a[0] !== exp_l || cnt_a !== exp_c) begin
        errors++;
        $display("FAIL midrst_press cycle %0d got evt=%b lvl=%b cnt=%0d want %b/%b/%0d",
                 c, evt_a[0], lvl_a[0], cnt_a, exp_e, exp_l, exp_c);
      end
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL midrst_evt_total got %0d want 1", n);
    end
    up = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {clr, dn, up} = 3'b000;
    test_reset();
    test_press_latency();
    test_glitch();
    test_wrap_sat();
    test_repeat();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
